// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, in-order fetch queue, redirect/halt control.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt the unit and raise misalign_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic [31:0] fetch_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        fcount_q, fcount_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        last_pc_q, last_pc_d, last_ins_q, last_ins_d;
  logic [31:0]        pc_mem_q [DEPTH];
  logic [31:0]        ins_mem_q [DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
  logic               misalign_q, misalign_d;
`endif

  logic empty, full, pop, push, redirect;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign pop      = !empty && out_ready;
  assign redirect = redirect_valid && (state_q != BOOT);
  // A redirect squashes the word fetched in the same cycle.
  assign push     = (state_q == RUN) && !redirect && (!full || pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcount_d   = fcount_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    last_pc_d  = last_pc_q;
    last_ins_d = last_ins_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (!empty) begin
      last_pc_d  = pc_mem_q[rd_ptr_q];
      last_ins_d = ins_mem_q[rd_ptr_q];
    end
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        state_d = RUN;
        pc_d    = redirect_target;
      end
`else
      state_d = RUN;
      pc_d    = redirect_target & ~32'h3;
`endif
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 32'd4;
        fcount_d = fcount_q + 32'd1;
        if (imem_instr == HALT_INSTR) state_d = HALT;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fcount_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      last_pc_q  <= '0;
      last_ins_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fcount_q   <= fcount_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      last_pc_q  <= last_pc_d;
      last_ins_q <= last_ins_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Queue storage carries data only; occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= pc_q;
      ins_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = !empty;
  assign out_pc      = empty ? last_pc_q  : pc_mem_q[rd_ptr_q];
  assign out_instr   = empty ? last_ins_q : ins_mem_q[rd_ptr_q];
  assign halted      = (state_q == HALT);
  assign fetch_count = fcount_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {pc,instr}; a negedge monitor checks deliveries.
module tb_fetch_unit;

  logic        clk, reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        halted;
  logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif
  logic [31:0] halt_addr;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks = 0;
  int   passes = 0;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .HALT_INSTR(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_instr = (imem_addr == halt_addr) ? 32'hFFFF_FFFF : 32'h1000_0000 + imem_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back('{pc: pc, ins: ins});
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected actual_pc=%h required=none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", out_pc, mon_e.pc);
        chk("sb_instr", out_instr, mon_e.ins);
      end
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; halt_addr = 32'h1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Back-pressure from reset release: BOOT cycle, then two pushes fill the queue.
    reset = 1'b0;
    tick();
    chk("boot_no_valid", 32'(out_valid), 32'd0);
    chk("boot_no_fetch", fetch_count, 32'd0);
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'd0);
    repeat (4) tick();
    chk("bp_count", fetch_count, 32'd2);
    chk("bp_addr_hold", imem_addr, 32'd8);
    chk("bp_head_pc", out_pc, 32'd0);

    // Free run: one pop and one push per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_pc(32'(4 * i), 32'h1000_0000 + 32'(4 * i));
      tick();
      chk("run_count", fetch_count, 32'(3 + i));
    end
    out_ready = 1'b0;
    chk("run_addr", imem_addr, 32'd32);

    // Redirect while queue holds 24,28.
    do_redirect(32'h40);
    chk("redir_flush", 32'(out_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    tick();
    chk("redir_valid", 32'(out_valid), 32'd1);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_instr", out_instr, 32'h1000_0040);
    tick();
    expect_pc(32'h40, 32'h1000_0040);
    expect_pc(32'h44, 32'h1000_0044);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;

    // Halt word at 0x0C.
    halt_addr = 32'h0C;
    do_redirect(32'h0);
    expect_pc(32'h0, 32'h1000_0000);
    expect_pc(32'h4, 32'h1000_0004);
    expect_pc(32'h8, 32'h1000_0008);
    expect_pc(32'hC, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", fetch_count, 32'd16);
    chk("halt_addr", imem_addr, 32'h10);
    chk("halt_empty", 32'(out_valid), 32'd0);
    chk("halt_hold_pc", out_pc, 32'hC);
    chk("halt_hold_instr", out_instr, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    halt_addr = 32'h1;
    do_redirect(32'h0);
    chk("unhalt", 32'(halted), 32'd0);
    chk("unhalt_addr", imem_addr, 32'h0);
    tick();
    chk("unhalt_pc", out_pc, 32'h0);
    tick();

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    repeat (2) tick();
    chk("wrap_addr", imem_addr, 32'h0);
    expect_pc(32'hFFFF_FFF8, 32'h0FFF_FFF8);
    expect_pc(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    expect_pc(32'h0000_0000, 32'h1000_0000);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("wrap_count", fetch_count, 32'd23);

    // Misaligned redirect target.
    do_redirect(32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_empty", 32'(out_valid), 32'd0);
    tick();
    chk("mis_no_fetch", 32'(out_valid), 32'd0);
`else
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_halted", 32'(halted), 32'd0);
    tick();
    chk("mis_valid", 32'(out_valid), 32'd1);
    chk("mis_pc", out_pc, 32'h40);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
